// File: rtl/motor_reg_pkg.sv
// Shared address-map constants, ctrl-register field layout and address helpers
// for the motor register bank.
package motor_reg_pkg;

    localparam int GLOBAL_STATUS = 'h00;
    localparam int BCAST_ALL     = 'h01;
    localparam int BCAST_ROT     = 'h02;
    localparam int BCAST_DRV     = 'h03;
    localparam int DRV_BASE      = 'h04;

    localparam int DRV_STRIDE      = 2;
    localparam int ROT_STRIDE      = 4;
    localparam int ROT_CTRL_OFS    = 0;
    localparam int ROT_STATUS_OFS  = 1;
    localparam int ROT_TARGET_OFS  = 2;
    localparam int ROT_CURRENT_OFS = 3;

    localparam int CTRL_BRAKE    = 7;
    localparam int CTRL_ENABLE   = 6;
    localparam int CTRL_DIR      = 5;
    localparam int CTRL_PWM_MSB  = 4;

    typedef struct packed {
        logic       brake;
        logic       enable;
        logic       direction;
        logic [4:0] pwm;
    } ctrl_t;

    function automatic int rot_base(input int num_drive);
        return DRV_BASE + DRV_STRIDE * num_drive;
    endfunction

    function automatic int servo_base(input int num_drive, input int num_rot);
        return rot_base(num_drive) + ROT_STRIDE * num_rot;
    endfunction

    // Motor index runs over drives first, then rotations.
    function automatic int ctrl_addr(input int idx, input int num_drive);
        if (idx < num_drive)
            return DRV_BASE + DRV_STRIDE * idx;
        return rot_base(num_drive) + ROT_STRIDE * (idx - num_drive) + ROT_CTRL_OFS;
    endfunction

    function automatic int status_addr(input int idx, input int num_drive);
        if (idx < num_drive)
            return DRV_BASE + DRV_STRIDE * idx + 1;
        return rot_base(num_drive) + ROT_STRIDE * (idx - num_drive) + ROT_STATUS_OFS;
    endfunction

endpackage

// File: rtl/motor_ctrl_reg.sv
// One per-motor control register {brake,enable,direction,pwm}: loaded by its own
// address or a matching broadcast, with enable forced low on fault edge or watchdog trip.
module motor_ctrl_reg
    import motor_reg_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       write_en,
    input  logic       addr_match,
    input  logic       bcast_match,
    input  logic [7:0] wr_data,
    input  logic       fault_rise,
    input  logic       wdog_clear,
    output logic [7:0] ctrl
);

    logic [7:0] ctrl_reg;
    logic [7:0] ctrl_next;

    always_comb begin
        ctrl_next = ctrl_reg;
        if (write_en && (addr_match || bcast_match))
            ctrl_next = wr_data;
        // Disable wins over a same-cycle write; the other fields still take wr_data.
        if (fault_rise || wdog_clear)
            ctrl_next[CTRL_ENABLE] = 1'b0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            ctrl_reg <= 8'h00;
        else
            ctrl_reg <= ctrl_next;
    end

    assign ctrl = ctrl_reg;

endmodule

// File: rtl/motor_reg_bank.sv
// SPI-side register bank for drive/rotation motors and servos with sticky faults,
// auto-disable and registered reads. Optional host watchdog: define MOTOR_REG_WDOG_EN.
module motor_reg_bank
    import motor_reg_pkg::*;
#(
    parameter int         NUM_DRIVE   = 4,
    parameter int         NUM_ROT     = 4,
    parameter int         NUM_SERVO   = 4,
    parameter int         ADDR_W      = 6,
    parameter logic [7:0] SERVO_RST   = 8'h80,
    parameter int         WDOG_CYCLES = 1000000
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic [ADDR_W-1:0]           address,
    input  logic                        write_en,
    input  logic [7:0]                  wr_data,
    input  logic                        read_en,
    output logic [7:0]                  rd_data,
    output logic                        rd_valid,
    input  logic [NUM_DRIVE+NUM_ROT-1:0]     fault,
    input  logic [7*(NUM_DRIVE+NUM_ROT)-1:0] adc_temp,
    input  logic [8*NUM_ROT-1:0]        current_angle,
    output logic [NUM_DRIVE+NUM_ROT-1:0]     brake,
    output logic [NUM_DRIVE+NUM_ROT-1:0]     enable,
    output logic [NUM_DRIVE+NUM_ROT-1:0]     direction,
    output logic [5*(NUM_DRIVE+NUM_ROT)-1:0] pwm,
    output logic [8*NUM_ROT-1:0]        target_angle,
    output logic [8*NUM_SERVO-1:0]      servo_position,
    output logic                        wdog_expired
);

    localparam int NM         = NUM_DRIVE + NUM_ROT;
    localparam int ROT_BASE   = rot_base(NUM_DRIVE);
    localparam int SERVO_BASE = servo_base(NUM_DRIVE, NUM_ROT);
    localparam int MAP_SIZE   = SERVO_BASE + NUM_SERVO;

    if (MAP_SIZE > (1 << ADDR_W)) begin : g_map_too_big
        $error("motor_reg_bank: address map needs %0d entries, ADDR_W too small", MAP_SIZE);
    end
    if (WDOG_CYCLES < 1) begin : g_bad_wdog
        $error("motor_reg_bank: WDOG_CYCLES must be at least 1");
    end

    logic [NM-1:0][7:0]        ctrl_bits;
    logic [NM-1:0][6:0]        temp_reg;
    logic [NM-1:0]             sticky_reg;
    logic [NM-1:0]             fault_reg;
    logic [NUM_ROT-1:0][7:0]   target_reg;
    logic [NUM_ROT-1:0][7:0]   current_reg;
    logic [NUM_SERVO-1:0][7:0] servo_reg;
    logic [7:0]                read_value;
    logic                      wdog_clear;
    logic                      is_bcast_all;
    logic                      is_bcast_rot;
    logic                      is_bcast_drv;

    assign is_bcast_all = (address == ADDR_W'(BCAST_ALL));
    assign is_bcast_rot = (address == ADDR_W'(BCAST_ROT));
    assign is_bcast_drv = (address == ADDR_W'(BCAST_DRV));

    genvar gi;

    for (gi = 0; gi < NM; gi++) begin : g_motor
        logic  addr_match;
        logic  bcast_match;
        logic  status_read;
        ctrl_t fields;

        assign addr_match  = (address == ADDR_W'(ctrl_addr(gi, NUM_DRIVE)));
        assign status_read = read_en && (address == ADDR_W'(status_addr(gi, NUM_DRIVE)));

        if (gi < NUM_DRIVE) begin : g_drv
            assign bcast_match = is_bcast_all || is_bcast_drv;
        end else begin : g_rot
            assign bcast_match = is_bcast_all || is_bcast_rot;
        end

        motor_ctrl_reg u_ctrl (
            .clock       (clock),
            .reset_n     (reset_n),
            .write_en    (write_en),
            .addr_match  (addr_match),
            .bcast_match (bcast_match),
            .wr_data     (wr_data),
            .fault_rise  (fault[gi] && !fault_reg[gi]),
            .wdog_clear  (wdog_clear),
            .ctrl        (ctrl_bits[gi])
        );

        // A live fault keeps the sticky bit set even during a clearing read.
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                fault_reg[gi]  <= 1'b0;
                sticky_reg[gi] <= 1'b0;
                temp_reg[gi]   <= 7'h00;
            end else begin
                fault_reg[gi] <= fault[gi];
                temp_reg[gi]  <= adc_temp[7*gi +: 7];
                if (fault[gi])
                    sticky_reg[gi] <= 1'b1;
                else if (status_read)
                    sticky_reg[gi] <= 1'b0;
            end
        end

        assign fields          = ctrl_t'(ctrl_bits[gi]);
        assign brake[gi]       = fields.brake;
        assign enable[gi]      = fields.enable;
        assign direction[gi]   = fields.direction;
        assign pwm[5*gi +: 5]  = fields.pwm;
    end

    for (gi = 0; gi < NUM_ROT; gi++) begin : g_rot_angle
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                target_reg[gi]  <= 8'h00;
                current_reg[gi] <= 8'h00;
            end else begin
                current_reg[gi] <= current_angle[8*gi +: 8];
                if (write_en && address == ADDR_W'(ROT_BASE + ROT_STRIDE*gi + ROT_TARGET_OFS))
                    target_reg[gi] <= wr_data;
            end
        end
        assign target_angle[8*gi +: 8] = target_reg[gi];
    end

    for (gi = 0; gi < NUM_SERVO; gi++) begin : g_servo
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n)
                servo_reg[gi] <= SERVO_RST;
            else if (write_en && address == ADDR_W'(SERVO_BASE + gi))
                servo_reg[gi] <= wr_data;
        end
        assign servo_position[8*gi +: 8] = servo_reg[gi];
    end

    always_comb begin
        read_value = 8'h00;
        if (address == ADDR_W'(GLOBAL_STATUS))
            read_value = {wdog_expired, |sticky_reg, 6'b0};
        for (int i = 0; i < NM; i++) begin
            if (address == ADDR_W'(ctrl_addr(i, NUM_DRIVE)))
                read_value = ctrl_bits[i];
            if (address == ADDR_W'(status_addr(i, NUM_DRIVE)))
                read_value = {sticky_reg[i], temp_reg[i]};
        end
        for (int i = 0; i < NUM_ROT; i++) begin
            if (address == ADDR_W'(ROT_BASE + ROT_STRIDE*i + ROT_TARGET_OFS))
                read_value = target_reg[i];
            if (address == ADDR_W'(ROT_BASE + ROT_STRIDE*i + ROT_CURRENT_OFS))
                read_value = current_reg[i];
        end
        for (int i = 0; i < NUM_SERVO; i++) begin
            if (address == ADDR_W'(SERVO_BASE + i))
                read_value = servo_reg[i];
        end
    end

    // Sampling before the same-edge update gives pre-write data on read+write.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_data  <= 8'h00;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= read_en;
            if (read_en)
                rd_data <= read_value;
        end
    end

`ifdef MOTOR_REG_WDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

    logic [WDOG_W-1:0] wdog_cnt_reg;
    logic              wdog_expired_reg;

    // Trip exactly on the 1->0 step; the counter then parks at 0 until a write.
    assign wdog_clear = !write_en && (wdog_cnt_reg == WDOG_W'(1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wdog_cnt_reg     <= WDOG_W'(WDOG_CYCLES);
            wdog_expired_reg <= 1'b0;
        end else if (write_en) begin
            wdog_cnt_reg     <= WDOG_W'(WDOG_CYCLES);
            wdog_expired_reg <= 1'b0;
        end else if (wdog_cnt_reg != '0) begin
            wdog_cnt_reg <= wdog_cnt_reg - WDOG_W'(1);
            if (wdog_clear)
                wdog_expired_reg <= 1'b1;
        end
    end

    assign wdog_expired = wdog_expired_reg;
`else
    assign wdog_clear   = 1'b0;
    assign wdog_expired = 1'b0;
`endif

endmodule

// File: tb/tb_motor_reg_bank.sv
// Directed test of motor_reg_bank with default geometry and a 16-clock watchdog.
module tb_motor_reg_bank;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [5:0]  address = '0;
    logic        write_en = 1'b0;
    logic [7:0]  wr_data = '0;
    logic        read_en = 1'b0;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic [7:0]  fault = '0;
    logic [55:0] adc_temp = '0;
    logic [31:0] current_angle = '0;
    logic [7:0]  brake;
    logic [7:0]  enable;
    logic [7:0]  direction;
    logic [39:0] pwm;
    logic [31:0] target_angle;
    logic [31:0] servo_position;
    logic        wdog_expired;

    int total = 0;
    int bad = 0;

    always #5 clock = ~clock;

    motor_reg_bank #(
        .NUM_DRIVE   (4),
        .NUM_ROT     (4),
        .NUM_SERVO   (4),
        .ADDR_W      (6),
        .SERVO_RST   (8'h80),
        .WDOG_CYCLES (16)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .address        (address),
        .write_en       (write_en),
        .wr_data        (wr_data),
        .read_en        (read_en),
        .rd_data        (rd_data),
        .rd_valid       (rd_valid),
        .fault          (fault),
        .adc_temp       (adc_temp),
        .current_angle  (current_angle),
        .brake          (brake),
        .enable         (enable),
        .direction      (direction),
        .pwm            (pwm),
        .target_angle   (target_angle),
        .servo_position (servo_position),
        .wdog_expired   (wdog_expired)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [5:0] a, input logic [7:0] d);
        @(negedge clock);
        address  = a;
        wr_data  = d;
        write_en = 1'b1;
        @(negedge clock);
        write_en = 1'b0;
        $display("wr addr=%02h data=%02h", a, d);
    endtask

    task automatic rd(input logic [5:0] a, input logic [7:0] exp);
        @(negedge clock);
        address = a;
        read_en = 1'b1;
        @(negedge clock);
        read_en = 1'b0;
        $display("rd addr=%02h data=%02h valid=%0b exp=%02h", a, rd_data, rd_valid, exp);
        chk($sformatf("rd_valid@%02h", a), 64'(rd_valid), 64'd1);
        chk($sformatf("rd_data@%02h", a), 64'(rd_data), 64'(exp));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rd_valid"}, 64'(rd_valid), 64'd0);
        chk({tag, "_rd_data"}, 64'(rd_data), 64'd0);
        chk({tag, "_enable"}, 64'(enable), 64'd0);
        chk({tag, "_brake"}, 64'(brake), 64'd0);
        chk({tag, "_direction"}, 64'(direction), 64'd0);
        chk({tag, "_pwm"}, 64'(pwm), 64'd0);
        chk({tag, "_target"}, 64'(target_angle), 64'd0);
        chk({tag, "_servo"}, 64'(servo_position), 64'h80808080);
        chk({tag, "_wdog"}, 64'(wdog_expired), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(negedge clock);
        chk_reset_outputs("reset");
        reset_n = 1'b1;

        // Whole map after reset: servos at centre, everything else zero.
        for (int a = 0; a < 34; a++)
            rd(6'(a), (a >= 'h1C && a < 'h20) ? 8'h80 : 8'h00);
        rd(6'h3F, 8'h00);
        @(negedge clock);
        chk("rd_valid_idle", 64'(rd_valid), 64'd0);

        // Writes to read-only / unmapped locations are dropped.
        wr(6'h25, 8'hFF);
        wr(6'h00, 8'hFF);
        rd(6'h00, 8'h00);

        // Drive broadcast leaves rotations untouched.
        wr(6'h03, 8'h5F);
        chk("bcast_drv_enable", 64'(enable), 64'h0F);
        chk("bcast_drv_pwm", 64'(pwm), 64'h00000FFFFF);
        rd(6'h04, 8'h5F);
        rd(6'h0A, 8'h5F);
        rd(6'h0C, 8'h00);
        rd(6'h18, 8'h00);

        wr(6'h01, 8'h41);
        chk("bcast_all_enable", 64'(enable), 64'hFF);
        chk("bcast_all_pwm", 64'(pwm), 64'h0842108421);
        rd(6'h06, 8'h41);
        rd(6'h14, 8'h41);

        wr(6'h02, 8'h22);
        rd(6'h0C, 8'h22);
        rd(6'h04, 8'h41);
        chk("bcast_rot_enable", 64'(enable), 64'h0F);
        chk("bcast_rot_dir", 64'(direction), 64'hF0);

        // Fault edge auto-disables channel 0 and sets its sticky bit.
        wr(6'h04, 8'h7F);
        chk("ctrl0_enable_set", 64'(enable[0]), 64'd1);
        @(negedge clock);
        fault[0] = 1'b1;
        @(negedge clock);
        chk("fault0_autodisable", 64'(enable[0]), 64'd0);
        rd(6'h04, 8'h3F);
        rd(6'h05, 8'h80);
        rd(6'h05, 8'h80);
        fault[0] = 1'b0;
        rd(6'h05, 8'h80);
        rd(6'h05, 8'h00);
        chk("fault0_stays_disabled", 64'(enable[0]), 64'd0);

        // Fault edge and write to the same ctrl in one cycle.
        @(negedge clock);
        address  = 6'h06;
        wr_data  = 8'hFF;
        write_en = 1'b1;
        fault[1] = 1'b1;
        @(negedge clock);
        write_en = 1'b0;
        fault[1] = 1'b0;
        $display("wr addr=06 data=ff with fault[1] edge");
        chk("fault1_write_enable", 64'(enable[1]), 64'd0);
        chk("fault1_write_brake", 64'(brake[1]), 64'd1);
        rd(6'h06, 8'hBF);
        rd(6'h07, 8'h80);
        rd(6'h07, 8'h00);

        // Temperature sampling into status.
        adc_temp[20:14] = 7'h55;
        adc_temp[41:35] = 7'h12;
        @(negedge clock);
        rd(6'h09, 8'h55);
        rd(6'h11, 8'h12);

        // Rotation target and live angle.
        wr(6'h12, 8'hA5);
        current_angle[15:8] = 8'h3C;
        chk("target_angle", 64'(target_angle), 64'h0000A500);
        rd(6'h13, 8'h3C);
        rd(6'h12, 8'hA5);
        wr(6'h13, 8'hFF);
        rd(6'h13, 8'h3C);

        // Servo write, then read+write same address returns old value.
        wr(6'h1D, 8'h10);
        chk("servo1", 64'(servo_position), 64'h80801080);
        @(negedge clock);
        address  = 6'h1D;
        wr_data  = 8'h20;
        write_en = 1'b1;
        read_en  = 1'b1;
        @(negedge clock);
        write_en = 1'b0;
        read_en  = 1'b0;
        $display("rd+wr addr=1d data=%02h", rd_data);
        chk("rw_same_old", 64'(rd_data), 64'h10);
        chk("rw_same_servo", 64'(servo_position), 64'h80802080);
        rd(6'h1D, 8'h20);

        // any_fault in global status follows the sticky bits.
        wr(6'h1C, 8'h80);
        @(negedge clock);
        fault[7] = 1'b1;
        @(negedge clock);
        fault[7] = 1'b0;
        rd(6'h00, 8'h40);
        rd(6'h19, 8'h80);
        rd(6'h00, 8'h00);

`ifdef MOTOR_REG_WDOG_EN
        wr(6'h01, 8'h40);
        chk("wdog_enable_all", 64'(enable), 64'hFF);
        repeat (15) @(negedge clock);
        chk("wdog_before_enable", 64'(enable), 64'hFF);
        chk("wdog_before_flag", 64'(wdog_expired), 64'd0);
        @(negedge clock);
        chk("wdog_trip_enable", 64'(enable), 64'h00);
        chk("wdog_trip_flag", 64'(wdog_expired), 64'd1);
        rd(6'h00, 8'h80);
        wr(6'h1F, 8'h80);
        chk("wdog_reload_flag", 64'(wdog_expired), 64'd0);
        chk("wdog_reload_enable", 64'(enable), 64'h00);
`else
        wr(6'h01, 8'h40);
        repeat (20) @(negedge clock);
        chk("nowdog_enable", 64'(enable), 64'hFF);
        chk("nowdog_flag", 64'(wdog_expired), 64'd0);
        rd(6'h00, 8'h00);
`endif

        // Asynchronous reset mid-transfer.
        wr(6'h01, 8'hE3);
        @(negedge clock);
        address = 6'h1D;
        read_en = 1'b1;
        @(posedge clock);
        #1;
        read_en = 1'b0;
        chk("mid_rd_valid", 64'(rd_valid), 64'd1);
        chk("mid_rd_data", 64'(rd_data), 64'h20);
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        @(negedge clock);
        reset_n = 1'b1;
        rd(6'h1D, 8'h80);
        rd(6'h12, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
